// File: rtl/ser_tx.sv
// Serial frame transmitter: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Define SER_TX_PARITY_EN to insert the parity bit between the last data bit and the stop bit.
module ser_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic             tx,
    output logic             busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

`ifdef SER_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    bit_idx;
    logic             bit_end;
    logic [WIDTH-1:0] sh_next;
`ifdef SER_TX_PARITY_EN
    logic             par;
`endif

    assign bit_end = (cnt == CNT_LAST);
    // tx is loaded with the next bit one edge early so the line is a pure register output
    assign sh_next = shreg >> 1;

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx      <= 1'b1;
            ready   <= 1'b1;
            busy    <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef SER_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        shreg   <= data_in;
`ifdef SER_TX_PARITY_EN
                        par     <= ^data_in;
`endif
                        state   <= START;
                        tx      <= 1'b0;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        bit_idx <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= DATA;
                        tx    <= shreg[0];
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            bit_idx <= '0;
`ifdef SER_TX_PARITY_EN
                            state   <= PARITY;
                            tx      <= par;
`else
                            state   <= STOP;
                            tx      <= 1'b1;
`endif
                        end else begin
                            shreg   <= sh_next;
                            tx      <= sh_next[0];
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef SER_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ser_tx.sv
// Randomized bench for ser_tx: a frame-level model expands each accepted word into its
// expected per-cycle line values and every negedge compares tx/ready/busy against it.
module tb_ser_tx;

    localparam int WIDTH = 8;
    localparam int CPB   = 4;
`ifdef SER_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int F = (2 + WIDTH + P) * CPB;

    logic             ck = 1'b0;
    logic             rst_n = 1'b0;
    logic             valid = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             ready, tx, busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // model: queue of line values for the cycles of the frame in flight
    bit q[$];
    bit m_tx = 1'b1, m_ready = 1'b1, m_busy = 1'b0;

    logic prev_busy = 1'b0;
    int   last_rise = -1;
    int   rise_gap  = 0;

    ser_tx #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB)) dut (
        .ck      (ck),
        .rst_n   (rst_n),
        .data_in (data_in),
        .valid   (valid),
        .ready   (ready),
        .tx      (tx),
        .busy    (busy)
    );

    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Advance the model across the next posedge using the current inputs, then check at negedge.
    task automatic tick();
        if (!rst_n) begin
            q.delete();
        end else if (m_ready && valid) begin
            bit [WIDTH-1:0] d;
            bit bits[$];
            d = data_in;
            bits.push_back(1'b0);
            for (int i = 0; i < WIDTH; i++) bits.push_back(d[i]);
            if (P == 1) bits.push_back(^d);
            bits.push_back(1'b1);
            foreach (bits[i]) repeat (CPB) q.push_back(bits[i]);
        end
        if (q.size() > 0) begin
            m_tx    = q.pop_front();
            m_ready = 1'b0;
            m_busy  = 1'b1;
        end else begin
            m_tx    = 1'b1;
            m_ready = 1'b1;
            m_busy  = 1'b0;
        end
        @(negedge ck);
        cyc++;
        chk("tx",    32'(tx),    32'(m_tx));
        chk("ready", 32'(ready), 32'(m_ready));
        chk("busy",  32'(busy),  32'(m_busy));
        if (busy === 1'b1 && prev_busy !== 1'b1) begin
            if (last_rise >= 0) rise_gap = cyc - last_rise;
            last_rise = cyc;
        end
        prev_busy = busy;
    endtask

    initial begin
        // reset held with valid asserted: no frame may start
        rst_n = 1'b0; valid = 1'b1; data_in = 8'h55;
        repeat (2) tick();
        rst_n = 1'b1; valid = 1'b0;
        tick();

        // single frames: 0xA5 (parity 0) and 0x07 (parity 1)
        data_in = 8'hA5; valid = 1'b1; tick();
        valid = 1'b0; data_in = 8'h3C;
        repeat (F + 3) tick();
        data_in = 8'h07; valid = 1'b1; tick();
        valid = 1'b0;
        repeat (F + 3) tick();

        // back-to-back with valid held: frame period must be F+1
        last_rise = -1; rise_gap = 0;
        data_in = 8'h00; valid = 1'b1; tick();
        data_in = 8'hFF;
        repeat (F + 1) tick();
        valid = 1'b0;
        repeat (F + 2) tick();
        chk("b2b_period", 32'(rise_gap), 32'(F + 1));

        // valid pulse and data change mid-frame are ignored
        data_in = 8'h81; valid = 1'b1; tick();
        valid = 1'b0;
        repeat (10) tick();
        data_in = 8'h3C; valid = 1'b1; tick();
        valid = 1'b0; data_in = 8'hFF;
        repeat (F) tick();

        // reset in the middle of data bit 3, then a clean frame
        data_in = 8'hC3; valid = 1'b1; tick();
        valid = 1'b0;
        repeat (CPB * 4 + 1) tick();
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        data_in = 8'h5A; valid = 1'b1; tick();
        valid = 1'b0;
        repeat (F + 2) tick();

        // randomized traffic with occasional resets
        repeat (3000) begin
            rst_n   = ($urandom_range(0, 299) != 0);
            valid   = ($urandom_range(0, 2) != 0);
            data_in = WIDTH'($urandom);
            tick();
        end
        rst_n = 1'b1; valid = 1'b0;
        repeat (F + 2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
